// File: rtl/display_pkg.sv
// display_pkg: shared scan-scheduler states, default timing constants and one-hot decode.
package display_pkg;
    typedef enum logic [1:0] {S_OFF, S_LOAD, S_ON, S_BLANK} state_e;
    localparam int DEF_PWM_STEPS   = 16;
    localparam int DEF_STEP_CYCLES = 15625;
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'(1) << idx;
    endfunction
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: counts 0..STEP_CYCLES-1 and pulses step_tick_o on the wrap cycle; clear_i restarts it.
module step_prescaler import display_pkg::*; #(
    parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear_i,
    output logic step_tick_o
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign step_tick_o = (cnt_q == CW'(STEP_CYCLES - 1));
    assign cnt_d = (clear_i || step_tick_o) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk_i) begin
        if (!reset_ni) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
endmodule

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler: multiplexes one 7-segment driver over NUM_DIGITS digits with PWM and guard blanking.
// Per-digit blink is built only when DISPLAY_BLINK_EN is defined.
module display_scan_scheduler import display_pkg::*; #(
    parameter int NUM_DIGITS  = 4,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int PWM_STEPS   = DEF_PWM_STEPS,
    parameter int GUARD_STEPS = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    enable_i,
    input  logic [3:0]              level_i,
    input  logic [4*NUM_DIGITS-1:0] digits_in_i,
    input  logic [NUM_DIGITS-1:0]   blink_mask_i,
    input  logic                    blink_tick_i,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic [3:0]              digit_val_o,
    output logic                    seg_on_o,
    output logic                    frame_done_o
);
    localparam int SLW    = $clog2(NUM_DIGITS);
    localparam int SW     = $clog2(PWM_STEPS + 1);
    localparam int MAX_ON = PWM_STEPS - GUARD_STEPS;

    state_e                  state_q, state_d;
    logic [SLW-1:0]          slot_q, slot_d;
    logic [SW-1:0]           step_q, step_d, on_q, on_d, slot_on_q, slot_on_d;
    logic [SW-1:0]           eff_level, cur_on, run_len;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d, cur_digits;
    logic [3:0]              digit_val_q, digit_val_d;
    logic                    frame_q, frame_d;
    logic                    step_tick, clear, first, last_slot, last_step, suppress;

    step_prescaler #(.STEP_CYCLES(STEP_CYCLES)) u_prescaler (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .clear_i     (clear),
        .step_tick_o (step_tick)
    );

    // Slot 0 reads the live inputs so the frame snapshot and its first digit agree.
    assign first      = (slot_q == '0);
    assign last_slot  = (slot_q == SLW'(NUM_DIGITS - 1));
    assign eff_level  = (int'(level_i) > MAX_ON) ? SW'(MAX_ON) : SW'(level_i);
    assign cur_on     = first ? eff_level : on_q;
    assign cur_digits = first ? digits_in_i : digits_q;
    assign run_len    = (state_q == S_ON) ? slot_on_q : SW'(PWM_STEPS) - slot_on_q;
    assign last_step  = step_tick && (step_q == run_len - SW'(1));

`ifdef DISPLAY_BLINK_EN
    logic                  blink_q;
    logic [NUM_DIGITS-1:0] mask_q;
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            blink_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            blink_q <= blink_q ^ blink_tick_i;
            if (state_q == S_LOAD && first) mask_q <= blink_mask_i;
        end
    end
    assign suppress = blink_q && (first ? blink_mask_i[slot_q] : mask_q[slot_q]);
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask_i, blink_tick_i};
    assign suppress     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        on_d        = on_q;
        slot_on_d   = slot_on_q;
        digits_d    = digits_q;
        digit_val_d = digit_val_q;
        frame_d     = 1'b0;
        case (state_q)
            S_OFF:  state_d = enable_i ? S_LOAD : S_OFF;
            S_LOAD: begin
                on_d        = cur_on;
                digits_d    = cur_digits;
                digit_val_d = cur_digits[{slot_q, 2'b00} +: 4];
                slot_on_d   = suppress ? '0 : cur_on;
                state_d     = (slot_on_d != '0) ? S_ON : S_BLANK;
            end
            S_ON:   state_d = last_step ? S_BLANK : S_ON;
            S_BLANK: begin
                if (last_step) begin
                    slot_d      = last_slot ? '0 : slot_q + SLW'(1);
                    frame_d     = last_slot;
                    state_d     = enable_i ? S_LOAD : S_OFF;
                    digit_val_d = enable_i ? digit_val_q : 4'd0;
                end
            end
            default: state_d = S_OFF;
        endcase
        clear  = (state_d != state_q) || !(state_q == S_ON || state_q == S_BLANK);
        step_d = clear ? '0 : step_q + SW'(step_tick);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_OFF;
            slot_q      <= '0;
            step_q      <= '0;
            on_q        <= '0;
            slot_on_q   <= '0;
            digits_q    <= '0;
            digit_val_q <= '0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            step_q      <= step_d;
            on_q        <= on_d;
            slot_on_q   <= slot_on_d;
            digits_q    <= digits_d;
            digit_val_q <= digit_val_d;
            frame_q     <= frame_d;
        end
    end

    assign digit_sel_o  = (state_q == S_ON) ? NUM_DIGITS'(onehot(3'(slot_q))) : '0;
    assign seg_on_o     = (state_q == S_ON);
    assign digit_val_o  = digit_val_q;
    assign frame_done_o = frame_q;
endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb_display_scan_scheduler: directed scan, saturation, snapshot, blink and control checks at
// STEP_CYCLES=2, PWM_STEPS=4, GUARD_STEPS=1, NUM_DIGITS=4 (9-cycle slots, 36-cycle frames).
module tb_display_scan_scheduler;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  level = 4'd0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  mask = 4'h0;
    logic        btick = 1'b0;
    logic [3:0]  sel;
    logic [3:0]  val;
    logic        seg;
    logic        fd;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          on_e, bl_e;

    always #5 clk = ~clk;

    display_scan_scheduler #(
        .NUM_DIGITS (4),
        .STEP_CYCLES(2),
        .PWM_STEPS  (4),
        .GUARD_STEPS(1)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .enable_i     (enable),
        .level_i      (level),
        .digits_in_i  (digits),
        .blink_mask_i (mask),
        .blink_tick_i (btick),
        .digit_sel_o  (sel),
        .digit_val_o  (val),
        .seg_on_o     (seg),
        .frame_done_o (fd)
    );

    task automatic step();
        @(posedge clk);
        #1;
        btick = 1'b0;
    endtask

    task automatic check(input string tag, input logic [3:0] es, input logic [3:0] ev,
                         input logic eg, input logic ef);
        n_cmp++;
        assert ({sel, val, seg, fd} === {es, ev, eg, ef}) else begin
            n_bad++;
            $error("FAIL %s: observed sel=%b val=%h seg=%b fd=%b, expected sel=%b val=%h seg=%b fd=%b",
                   tag, sel, val, seg, fd, es, ev, eg, ef);
        end
    endtask

    task automatic run_slot(input string tag, input logic [3:0] es, input logic [3:0] ev,
                            input int on_c, input int bl_c);
        for (int i = 0; i < on_c; i++) begin
            check({tag, "_on"}, es, ev, 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < bl_c; i++) begin
            check({tag, "_blank"}, 4'b0000, ev, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic slot(input string tag, input logic [3:0] es, input logic [3:0] ev,
                        input int on_c, input int bl_c, input logic ef);
        run_slot(tag, es, ev, on_c, bl_c);
        check({tag, "_load"}, 4'b0000, ev, 1'b0, ef);
        step();
    endtask

    initial begin
        repeat (3) step();
        check("reset", 4'b0000, 4'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle", 4'b0000, 4'h0, 1'b0, 1'b0);
        end
        enable = 1'b1;
        level  = 4'd2;
        digits = 16'h4321;
        step();
        check("first_load", 4'b0000, 4'h0, 1'b0, 1'b0);
        step();
        slot("f1s0", 4'b0001, 4'h1, 4, 4, 1'b0);
        digits = 16'h9999;
        level  = 4'd15;
        slot("f1s1", 4'b0010, 4'h2, 4, 4, 1'b0);
        slot("f1s2", 4'b0100, 4'h3, 4, 4, 1'b0);
        slot("f1s3", 4'b1000, 4'h4, 4, 4, 1'b1);
        slot("f2s0", 4'b0001, 4'h9, 6, 2, 1'b0);
        level = 4'd0;
        slot("f2s1", 4'b0010, 4'h9, 6, 2, 1'b0);
        slot("f2s2", 4'b0100, 4'h9, 6, 2, 1'b0);
        slot("f2s3", 4'b1000, 4'h9, 6, 2, 1'b1);
        slot("f3s0", 4'b0001, 4'h9, 0, 8, 1'b0);
        level  = 4'd2;
        digits = 16'h4321;
        mask   = 4'b0101;
        btick  = 1'b1;
        slot("f3s1", 4'b0010, 4'h9, 0, 8, 1'b0);
        slot("f3s2", 4'b0100, 4'h9, 0, 8, 1'b0);
        slot("f3s3", 4'b1000, 4'h9, 0, 8, 1'b1);
`ifdef DISPLAY_BLINK_EN
        on_e = 0;
        bl_e = 8;
`else
        on_e = 4;
        bl_e = 4;
`endif
        slot("f4s0", 4'b0001, 4'h1, on_e, bl_e, 1'b0);
        slot("f4s1", 4'b0010, 4'h2, 4, 4, 1'b0);
        slot("f4s2", 4'b0100, 4'h3, on_e, bl_e, 1'b0);
        btick = 1'b1;
        slot("f4s3", 4'b1000, 4'h4, 4, 4, 1'b1);
        slot("f5s0", 4'b0001, 4'h1, 4, 4, 1'b0);
        slot("f5s1", 4'b0010, 4'h2, 4, 4, 1'b0);
        enable = 1'b0;
        run_slot("f5s2", 4'b0100, 4'h3, 4, 4);
        for (int i = 0; i < 10; i++) begin
            check("parked", 4'b0000, 4'h0, 1'b0, 1'b0);
            step();
        end
        enable = 1'b1;
        step();
        check("resume_load", 4'b0000, 4'h0, 1'b0, 1'b0);
        step();
        check("resume_on", 4'b1000, 4'h4, 1'b1, 1'b0);
        step();
        reset_n = 1'b0;
        step();
        check("reset_mid_on", 4'b0000, 4'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step();
        check("post_reset_load", 4'b0000, 4'h0, 1'b0, 1'b0);
        step();
        check("post_reset_slot0", 4'b0001, 4'h1, 1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/display_scan_scheduler.md
Name: display_scan_scheduler

Overview:
Time-multiplexes one shared 7-segment driver across NUM_DIGITS digits.
Per digit slot, applies PWM brightness from a programmable level and a guard blank between digits.
Optional per-digit blink is supported.
Sits between the time/state datapath (digit values) and the board anode/segment pins; replaces fixed-duty brightness strobes with a sequenced scheduler.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
STEP_CYCLES, 15625, clk cycles per PWM step (prescaler terminal count)
PWM_STEPS, 16, PWM steps per digit slot; level range 0..PWM_STEPS-1
GUARD_STEPS, 1, minimum blank steps at end of every slot (anti-ghosting)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = scanning runs; 0 = finish current slot, then park blanked
level  in  4  brightness; ON steps per slot = min(level, PWM_STEPS-GUARD_STEPS)
digits_in  in  4*NUM_DIGITS  BCD/hex per digit; digit 0 = bits [3:0]
blink_mask  in  NUM_DIGITS  1 = digit participates in blink
blink_tick  in  1  one-cycle strobe; toggles blink phase
digit_sel  out  NUM_DIGITS  one-hot active-high anode select; all-zero when blanked
digit_val  out  4  value of the currently selected digit
seg_on  out  1  1 only while digit_sel is non-zero
frame_done  out  1  one-cycle pulse after last slot's BLANK completes

Behaviour:
- Clocking and reset: all logic on posedge clk. reset==0 sampled at an edge forces:
  - state=OFF, slot=0, prescaler=0, step=0, blink_phase=0
  - digit_sel=0, digit_val=0, seg_on=0, frame_done=0
  - Applies mid-slot too: outputs blank on the very next edge.
- Prescaler: counts 0..STEP_CYCLES-1 and wraps. step_tick is asserted on the wrap cycle.
- Prescaler and step counter run only in ON/BLANK. Both clear on every state entry.
- States:
  - OFF: outputs blank. Go to LOAD when enable=1.
  - LOAD (exactly 1 cycle):
    - If slot==0, snapshot digits_in, blink_mask, and the effective level into frame registers. Mid-frame input changes take effect next frame.
    - Latch digit_val from the snapshot for the current slot.
    - Next state = ON if on_steps>0 and the digit is not blink-suppressed; else BLANK.
  - ON:
    - digit_sel=one-hot(slot), seg_on=1.
    - Stay for on_steps step_ticks, then BLANK.
  - BLANK:
    - digit_sel=0, seg_on=0, digit_val held.
    - Stay for PWM_STEPS-on_steps step_ticks, which is always >= GUARD_STEPS.
    - Then advance slot:
      - If slot==NUM_DIGITS-1: wrap slot to 0 and pulse frame_done for 1 cycle (same edge as the transition).
      - If enable==0 at slot end: go to OFF. Otherwise go to LOAD.
- Width rules:
  - level > PWM_STEPS-GUARD_STEPS saturates; no wrap.
  - Slot period is always 1 + PWM_STEPS*STEP_CYCLES cycles, independent of level.
- Blink: blink_tick toggles blink_phase on the cycle it is high. A digit is suppressed when blink_phase==1 and its snapshot mask bit is 1.
- Simultaneous events:
  - reset beats everything.
  - blink_tick coinciding with LOAD uses the pre-toggle phase.
  - enable falling during ON does not truncate the ON time.

Optional Feature:
DISPLAY_BLINK_EN
- Defined: blink_phase register and suppression logic are present as described.
- Undefined: blink_mask and blink_tick are ignored, no blink_phase register is built, and a digit is never suppressed. Ports remain for a stable interface.

Decomposition:
- Shared package display_pkg: state enum (OFF, LOAD, ON, BLANK), onehot decode function, default PWM_STEPS/STEP_CYCLES constants.
- One sub-module: step_prescaler (STEP_CYCLES counter with clear input and step_tick output), reusable by other timed blocks.

Test Plan:
All tests use STEP_CYCLES=2, PWM_STEPS=4, GUARD_STEPS=1, NUM_DIGITS=4.
- Reset/idle: reset=0 for 3 cycles, then reset=1 with enable=0 -> all outputs 0 and stay 0 for 50 cycles.
- Full scan: enable=1, level=2, digits_in=0x4321.
  - digit_sel=0001 with digit_val=1 for 4 cycles, then 0 for 4 cycles.
  - Then 0010 with digit_val=2, etc.
  - frame_done pulses every 36 cycles.
- Saturation and zero:
  - level=15 -> ON 6 cycles and BLANK 2 cycles per slot.
  - level=0 -> digit_sel never non-zero, but frame_done still every 36 cycles.
- Snapshot: change digits_in to 0x9999 while slot 1 is ON -> slots 1..3 still show 2,3,4; the next frame shows 9s.
- Blink (DISPLAY_BLINK_EN defined): blink_mask=0101, pulse blink_tick once -> next frame digits 0 and 2 dark, digits 1 and 3 lit. Second pulse -> all lit.
- Mid-operation control:
  - Drop enable during slot 2 ON -> slot 2 completes ON+BLANK, then OFF with outputs 0.
  - reset=0 during ON -> digit_sel=0 on the next edge.
